// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: sends one byte to the device with open-drain low-enables and odd parity.
// Define PS2_TX_FILTER_EN to add a stability filter on the synchronized ps2_clock.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       n_res,
  input  logic       clk0,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  input  logic       status_ack,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_low,
  output logic       ps2_data_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             clk_meta_q, clk_meta_d;
  logic             clk_sync_q, clk_sync_d;
  logic             data_meta_q, data_meta_d;
  logic             data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic             wr_q, wr_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  tout_cnt_q, tout_cnt_d;
  logic             clock_low_q, clock_low_d;
  logic             data_low_q, data_low_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_level;
  logic fall;
  logic start;
  logic in_active;
  logic tout_hit;

`ifdef PS2_TX_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN) + 1;

  logic             filt_q, filt_d;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;

  // The filtered level only follows a new value held for FILTER_LEN consecutive cycles.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_res) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign clk_level = filt_q;
`else
  assign clk_level = clk_sync_q;
`endif

  assign fall      = clk_prev_q & ~clk_level;
  assign start     = clk0 & tx_wr & ~wr_q & (state_q == S_IDLE);
  assign in_active = (state_q == S_REQ) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                     (state_q == S_STOP) || (state_q == S_WAIT_IDLE);
  assign tout_hit  = (tout_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    clk_meta_d  = ps2_clock;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data;
    data_sync_d = data_meta_q;
    clk_prev_d  = clk_level;
    wr_d        = clk0 ? tx_wr : wr_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    inh_cnt_d   = inh_cnt_q;
    tout_cnt_d  = tout_cnt_q;
    clock_low_d = clock_low_q;
    data_low_d  = data_low_q;
    done_d      = done_q;
    err_d       = err_q;

    // Flag sets below are applied after this, so a set on the same cycle wins.
    if (status_ack) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    if (in_active && (tout_cnt_q != {TO_W{1'b1}})) begin
      tout_cnt_d = tout_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        clock_low_d = 1'b0;
        data_low_d  = 1'b0;
        if (start) begin
          shift_d     = tx_data;
          parity_d    = ~^tx_data;
          done_d      = 1'b0;
          err_d       = 1'b0;
          inh_cnt_d   = '0;
          clock_low_d = 1'b1;
          state_d     = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clock_low_d = 1'b0;
          data_low_d  = 1'b1;
          tout_cnt_d  = '0;
          state_d     = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = 4'd1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          if (bit_cnt_q == 4'd8) begin
            data_low_d = ~parity_q;
            state_d    = S_PARITY;
          end else begin
            data_low_d = ~shift_q[0];
            shift_d    = {1'b0, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          data_low_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          if (!data_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_level && data_sync_q) begin
          done_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout overrides whatever the frame did this cycle, including a completing ack.
    if (in_active && tout_hit) begin
      clock_low_d = 1'b0;
      data_low_d  = 1'b0;
      err_d       = 1'b1;
      done_d      = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_res) begin
      state_q     <= S_IDLE;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_prev_q  <= 1'b1;
      wr_q        <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      tout_cnt_q  <= '0;
      clock_low_q <= 1'b0;
      data_low_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      wr_q        <= wr_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
      clock_low_q <= clock_low_d;
      data_low_q  <= data_low_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ps2_clock_low = clock_low_q;
  assign ps2_data_low  = data_low_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign rx_inhibit    = (state_q != S_IDLE);
  assign tx_done       = done_q;
  assign tx_err        = err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with an open-drain PS/2 device model (scaled device clock, shortened timeout).
module tb_ps2_transmitter;

  localparam int INH  = 6000;
  localparam int TOUT = 8000;
  localparam int HALF = 150;

  logic       clk = 1'b0;
  logic       n_res = 1'b0;
  logic       clk0 = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       status_ack = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clock;
  wire        ps2_data;
  logic       ps2_clock_low, ps2_data_low, tx_busy, tx_done, tx_err, rx_inhibit;

  int compared = 0;
  int mismatched = 0;

  assign ps2_clock = ~(ps2_clock_low | dev_clk_low);
  assign ps2_data  = ~(ps2_data_low | dev_data_low);

  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .FILTER_LEN(8)) dut (
    .clk(clk), .n_res(n_res), .clk0(clk0), .tx_wr(tx_wr), .tx_data(tx_data),
    .status_ack(status_ack), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .ps2_clock_low(ps2_clock_low), .ps2_data_low(ps2_data_low), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit)
  );

  always #10 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    tx_data = d;
    tx_wr = 1'b1;
    wait_cycles(1);
    tx_wr = 1'b0;
  endtask

  // Counts cycles the host holds the clock low after a start, ending at request-to-send.
  task automatic wait_rts(output int low_cycles);
    low_cycles = 0;
    while (ps2_clock_low === 1'b1 && low_cycles < INH + 50) begin
      low_cycles++;
      wait_cycles(1);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 3000) begin
      n++;
      wait_cycles(1);
    end
    ok = (tx_busy === 1'b0);
  endtask

  // Device side: bits[0]=start, [1..8]=data LSB first, [9]=parity, [10]=stop.
  // hook_kind 1: CPU write of 0x00 in that clock's low phase; 2: assert reset there and abort;
  // 3: 3-cycle low glitch in that clock's high phase.
  task automatic device_frame(input bit ack, input int hook_fall, input int hook_kind,
                              output logic [10:0] bits);
    bits = '0;
    bits[0] = ps2_data;
    wait_cycles(50);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      wait_cycles(HALF);
      if (hook_kind == 1 && i == hook_fall) cpu_write(8'h00);
      if (hook_kind == 2 && i == hook_fall) begin
        n_res = 1'b0;
        return;
      end
      bits[i] = ps2_data;
      dev_clk_low = 1'b0;
      if (hook_kind == 3 && i == hook_fall) begin
        wait_cycles(40);
        dev_clk_low = 1'b1;
        wait_cycles(3);
        dev_clk_low = 1'b0;
        wait_cycles(HALF - 43);
      end else begin
        wait_cycles(HALF);
      end
    end
    dev_data_low = ack;
    wait_cycles(HALF);
    dev_clk_low = 1'b1;
    wait_cycles(HALF);
    dev_clk_low = 1'b0;
    wait_cycles(20);
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset;
    n_res = 1'b0;
    wait_cycles(3);
    compared++;
    if (ps2_clock_low !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_clock_low: got %b expected 0", ps2_clock_low); end
    compared++;
    if (ps2_data_low !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_data_low: got %b expected 0", ps2_data_low); end
    compared++;
    if (tx_busy !== 1'b0 || rx_inhibit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", tx_busy, rx_inhibit); end
    compared++;
    if (tx_done !== 1'b0 || tx_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got %b/%b expected 0/0", tx_done, tx_err); end
    n_res = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_ack_ed;
    int low_cycles;
    logic [10:0] bits;
    bit ok;
    cpu_write(8'hED);
    compared++;
    if (tx_busy !== 1'b1 || rx_inhibit !== 1'b1) begin mismatched++; $display("[TB] FAIL ed_busy: got %b/%b expected 1/1", tx_busy, rx_inhibit); end
    wait_rts(low_cycles);
    compared++;
    if (low_cycles != INH) begin mismatched++; $display("[TB] FAIL ed_inhibit_len: got %0d expected %0d", low_cycles, INH); end
    compared++;
    if (ps2_data_low !== 1'b1) begin mismatched++; $display("[TB] FAIL ed_start_bit: got data_low %b expected 1", ps2_data_low); end
    device_frame(1'b1, 0, 0, bits);
    compared++;
    if (bits !== 11'b1_1_11101101_0) begin mismatched++; $display("[TB] FAIL ed_frame: got %b expected %b", bits, 11'b1_1_11101101_0); end
    wait_idle(ok);
    compared++;
    if (!ok || tx_done !== 1'b1 || tx_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ed_ack: got busy %b done %b err %b expected 0 1 0", tx_busy, tx_done, tx_err); end
    status_ack = 1'b1;
    wait_cycles(1);
    status_ack = 1'b0;
    compared++;
    if (tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL ed_status_ack: got done %b expected 0", tx_done); end
  endtask

  task automatic test_nack_f4;
    int low_cycles;
    logic [10:0] bits;
    bit ok;
    cpu_write(8'hF4);
    wait_rts(low_cycles);
    device_frame(1'b0, 0, 0, bits);
    compared++;
    if (bits[9] !== 1'b0) begin mismatched++; $display("[TB] FAIL f4_parity: got %b expected 0", bits[9]); end
    compared++;
    if (bits !== 11'b1_0_11110100_0) begin mismatched++; $display("[TB] FAIL f4_frame: got %b expected %b", bits, 11'b1_0_11110100_0); end
    wait_idle(ok);
    compared++;
    if (!ok || tx_err !== 1'b1 || tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL f4_nack: got busy %b done %b err %b expected 0 0 1", tx_busy, tx_done, tx_err); end
    status_ack = 1'b1;
    wait_cycles(1);
    status_ack = 1'b0;
    compared++;
    if (tx_err !== 1'b0) begin mismatched++; $display("[TB] FAIL f4_status_ack: got err %b expected 0", tx_err); end
  endtask

  task automatic test_timeout_ff;
    int low_cycles;
    int n = 0;
    cpu_write(8'hFF);
    wait_rts(low_cycles);
    while (tx_err !== 1'b1 && n < TOUT + 100) begin
      n++;
      wait_cycles(1);
    end
    compared++;
    if (n != TOUT) begin mismatched++; $display("[TB] FAIL ff_timeout_len: got %0d expected %0d", n, TOUT); end
    compared++;
    if (ps2_clock_low !== 1'b0 || ps2_data_low !== 1'b0) begin mismatched++; $display("[TB] FAIL ff_release: got %b/%b expected 0/0", ps2_clock_low, ps2_data_low); end
    compared++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL ff_flags: got busy %b done %b expected 0 0", tx_busy, tx_done); end
  endtask

  task automatic test_back_to_back;
    int low_cycles;
    logic [10:0] bits;
    bit ok;
    cpu_write(8'hED);
    wait_rts(low_cycles);
    device_frame(1'b1, 3, 1, bits);
    compared++;
    if (bits !== 11'b1_1_11101101_0) begin mismatched++; $display("[TB] FAIL b2b_frame: got %b expected %b", bits, 11'b1_1_11101101_0); end
    wait_idle(ok);
    compared++;
    if (!ok || tx_done !== 1'b1 || tx_err !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_done: got busy %b done %b err %b expected 0 1 0", tx_busy, tx_done, tx_err); end
    wait_cycles(200);
    compared++;
    if (tx_busy !== 1'b0 || ps2_clock_low !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_no_second: got busy %b clock_low %b expected 0 0", tx_busy, ps2_clock_low); end
  endtask

  task automatic test_reset_midframe;
    int low_cycles;
    logic [10:0] bits;
    bit ok;
    cpu_write(8'hED);
    wait_rts(low_cycles);
    device_frame(1'b1, 5, 2, bits);
    compared++;
    if (ps2_data_low !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_bit4: got data_low %b expected 1", ps2_data_low); end
    wait_cycles(1);
    compared++;
    if (ps2_clock_low !== 1'b0 || ps2_data_low !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_release: got %b/%b expected 0/0", ps2_clock_low, ps2_data_low); end
    compared++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_flags: got %b%b%b expected 000", tx_busy, tx_done, tx_err); end
    n_res = 1'b1;
    dev_clk_low = 1'b0;
    wait_cycles(10);
    cpu_write(8'hED);
    wait_rts(low_cycles);
    compared++;
    if (low_cycles != INH) begin mismatched++; $display("[TB] FAIL mid_inhibit_len: got %0d expected %0d", low_cycles, INH); end
    device_frame(1'b1, 0, 0, bits);
    compared++;
    if (bits !== 11'b1_1_11101101_0) begin mismatched++; $display("[TB] FAIL mid_frame: got %b expected %b", bits, 11'b1_1_11101101_0); end
    wait_idle(ok);
    compared++;
    if (!ok || tx_done !== 1'b1 || tx_err !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_done: got busy %b done %b err %b expected 0 1 0", tx_busy, tx_done, tx_err); end
  endtask

`ifdef PS2_TX_FILTER_EN
  task automatic test_filter_glitch;
    int low_cycles;
    logic [10:0] bits;
    bit ok;
    cpu_write(8'hED);
    wait_rts(low_cycles);
    device_frame(1'b1, 3, 3, bits);
    compared++;
    if (bits !== 11'b1_1_11101101_0) begin mismatched++; $display("[TB] FAIL glitch_frame: got %b expected %b", bits, 11'b1_1_11101101_0); end
    wait_idle(ok);
    compared++;
    if (!ok || tx_done !== 1'b1) begin mismatched++; $display("[TB] FAIL glitch_done: got busy %b done %b expected 0 1", tx_busy, tx_done); end
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_ack_ed();
    test_nack_f4();
    test_timeout_ff();
    test_back_to_back();
    test_reset_midframe();
`ifdef PS2_TX_FILTER_EN
    test_filter_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
- Host-to-device PS/2 transmitter; the send-side counterpart of the PS/2 keyboard receiver on EXT_P[7] (clock) and EXT_P[4] (data).
- Lets the CPU send command bytes to the keyboard (LED set 0xED, reset 0xFF, enable 0xF4) via an I/O write.
- Drives both lines open-drain through "pull low" enables, sequences the full frame (inhibit, request-to-send, 8 data, odd parity, stop, ack), and reports done/error.
- Holds the receiver off while busy.

Parameters:
- INHIBIT_CYCLES, 6000, clk cycles clock is held low before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, clk cycles allowed from request-to-send to ack complete (15 ms at 50 MHz).
- FILTER_LEN, 8, clk cycles ps2_clock must be stable to be accepted (used only with the optional feature).

Ports:
- clk  in  1  50 MHz system clock
- n_res  in  1  reset, synchronous, active-low
- clk0  in  1  CPU clock phase strobe; qualifies tx_wr sampling
- tx_wr  in  1  CPU I/O write decode for the transmit port (level)
- tx_data  in  8  byte to send (CPU data bus)
- status_ack  in  1  1-cycle pulse; clears tx_done and tx_err
- ps2_clock  in  1  raw PS/2 clock pin
- ps2_data  in  1  raw PS/2 data pin
- ps2_clock_low  out  1  1 = drive clock pin low, 0 = release (Z)
- ps2_data_low  out  1  1 = drive data pin low, 0 = release (Z)
- tx_busy  out  1  frame in progress
- tx_done  out  1  sticky: last frame acked by device
- tx_err  out  1  sticky: last frame timed out or was NACKed
- rx_inhibit  out  1  equals tx_busy; receiver ignores line activity

Behaviour:
- Reset (n_res=0 at a clk edge): state IDLE; ps2_clock_low=0, ps2_data_low=0; tx_busy=0, tx_done=0, tx_err=0. Reset mid-frame releases both lines on the next clk edge.
- Inputs: ps2_clock and ps2_data pass through 2-FF synchronizers. fall = synced clock previous 1, now 0.
- Start:
  - Register wr_q is updated only when clk0=1.
  - A start is accepted on the clk edge where clk0=1, tx_wr=1, wr_q=0, and state is IDLE.
  - tx_data is latched into the shift register and odd parity is computed (parity = ~^tx_data).
  - tx_done and tx_err clear.
  - A start while busy is ignored.
- States:
  - IDLE: lines released. On start, go to INHIBIT and set tx_busy=1.
  - INHIBIT: ps2_clock_low=1 for exactly INHIBIT_CYCLES cycles. Then set ps2_data_low=1 (start bit 0), release clock, clear the timeout counter, and go to REQ.
  - REQ: wait for fall. On fall, drive data bit 0 (ps2_data_low = ~bit) and go to DATA with bit count 1.
  - DATA: on each fall, drive the next bit, LSB first. On the fall after bit 7 is driven, drive parity and go to PARITY.
  - PARITY: on fall, release data (stop bit 1) and go to STOP.
  - STOP: on fall, sample synced data. 0 means ACK; go to WAIT_IDLE. 1 means NACK; set tx_err and go to IDLE.
  - WAIT_IDLE: when synced clock=1 and data=1, set tx_done=1 and go to IDLE.
- Data changes only on the cycle after a detected fall, so it is stable before the device samples on the rising edge.
- Timeout:
  - Counter runs in REQ..WAIT_IDLE.
  - At TIMEOUT_CYCLES: release both lines, set tx_err=1, go to IDLE.
  - If ack completes on the same cycle as the timeout, the timeout wins.
- tx_busy=0 in IDLE only. tx_done and tx_err are mutually exclusive.
- status_ack clears both flags. If a flag set and status_ack occur on the same cycle, the set wins.
- Counter widths are $clog2 of the respective parameter plus 1. Counters saturate and never wrap.

Optional Feature:
- Macro: PS2_TX_FILTER_EN.
- Defined: the synced ps2_clock feeds a stability filter. The filtered level changes only after the input holds its new value for FILTER_LEN consecutive clk cycles, and fall is derived from the filtered level. This adds FILTER_LEN cycles of latency per edge.
- Undefined: fall is taken directly from the 2-FF synchronizer output.

Test Plan:
- Write 0xED with a device model clocking at 12.5 kHz. Expect clock held low for 6000 cycles, then start bit 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACK gives tx_done=1, tx_err=0, tx_busy=0.
- Write 0xF4. Expect parity bit 0 on the wire. Device NACK (data high at ack clock) gives tx_err=1, tx_done=0.
- Write 0xFF with the device never clocking. Expect tx_err=1 exactly TIMEOUT_CYCLES after request-to-send, and both low-enables 0.
- Second tx_wr of 0x00 during the DATA state. Expect it ignored: the wire carries only the first byte, with one tx_done.
- Assert n_res during bit 4 of 0xED. Expect ps2_clock_low=ps2_data_low=0 and all flags 0 on the next edge. A following write of 0xED completes normally.
- With PS2_TX_FILTER_EN: a 3-cycle low glitch on ps2_clock during DATA gives no bit advance, and the frame still completes with tx_done=1.
